// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery arithmetic blocks.
package mont_pkg;

  // Controller states shared by the mont_* sequencers.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SUB  = 2'd2,
    ERR  = 2'd3
  } mont_state_e;

  // Bits needed for a down-counter that must hold the value n.
  function automatic int unsigned mont_cnt_bits(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mont_iter.sv
// One radix-2 Montgomery step: S_next = (S + a_i*B [+ P if odd]) / 2.
// The accumulator carries two extra bits so S + B + P never wraps.
module mont_iter
  import mont_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH+1:0] s,
  input  logic             a_i,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH+1:0] s_next
);

  logic [WIDTH+1:0] sum_b;
  logic [WIDTH+1:0] sum_p;

  // Add the partial product, make the sum even with P, then halve it.
  always_comb begin
    sum_b  = s + (a_i ? {2'b00, b} : '0);
    sum_p  = sum_b[0] ? (sum_b + {2'b00, p}) : sum_b;
    s_next = sum_p >> 1;
  end

endmodule

// File: rtl/mont_mul_param.sv
// Bit-serial Montgomery multiplier: M = A*B*2^-WIDTH mod P.
// One iteration per clock, final conditional subtraction in its own cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an accepted start; M/err hold the last result
// CALC  | WIDTH radix-2 iterations, LSB of the captured A first
// SUB   | final reduction into M, done pulse issued on leaving
// ERR   | captured P was even; M=0, err=1, done pulse issued on leaving
module mont_mul_param
  import mont_pkg::*;
#(
  parameter int WIDTH      = 256,
  parameter bit START_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] M,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mont_state_e      state_q;
  mont_state_e      state_d;
  logic [WIDTH+1:0] s_q;
  logic [WIDTH+1:0] s_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_sub;
  logic             done_q;
  logic             err_q;
  logic             armed_q;
  logic             accept;

  // A request is taken only from IDLE; with START_HOLD the start line must
  // have been seen low since the previous accept, so a held level fires once.
  assign accept = (state_q == IDLE) && start && (!START_HOLD || armed_q);

  mont_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .s      (s_q),
    .a_i    (a_q[0]),
    .b      (b_q),
    .p      (p_q),
    .s_next (s_next)
  );

  // Final reduction: the loop leaves S below 2P for in-range operands.
  always_comb begin
    m_sub = s_q[WIDTH-1:0];
    if (s_q >= {2'b00, p_q}) begin
      m_sub = WIDTH'(s_q - {2'b00, p_q});
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = P[0] ? CALC : ERR;
        end
      end
      CALC: begin
        if (cnt_q == CNT_ONE) begin
          state_d = SUB;
        end
      end
      SUB:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, iteration datapath, result and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (!start) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            p_q     <= P;
            s_q     <= '0;
            cnt_q   <= CNT_LOAD;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
          end
        end
        CALC: begin
          s_q   <= s_next;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q - CNT_ONE;
        end
        SUB: begin
          m_q    <= m_sub;
          done_q <= 1'b1;
        end
        ERR: begin
          m_q    <= '0;
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end
        default: begin
          s_q <= '0;
        end
      endcase
    end
  end

  assign M    = m_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mont_mul_param.sv
// Bench for mont_mul_param: directed WIDTH=8 cases on a level-start and a
// free-running-start instance, plus random WIDTH=256 vectors checked against
// a modular-arithmetic reference.
module tb_mont_mul_param;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // WIDTH=8, START_HOLD=1
  logic       h_start;
  logic [7:0] h_a, h_b, h_p, h_m;
  logic       h_done, h_busy, h_err;

  // WIDTH=8, START_HOLD=0
  logic       b_start;
  logic [7:0] b_a, b_b, b_p, b_m;
  logic       b_done, b_busy, b_err;

  // WIDTH=256, START_HOLD=1
  logic         w_start;
  logic [255:0] w_a, w_b, w_p, w_m;
  logic         w_done, w_busy, w_err;

  mont_mul_param #(.WIDTH(8), .START_HOLD(1'b1)) u_h8 (
    .clk(clk), .rst_n(rst_n), .start(h_start), .A(h_a), .B(h_b), .P(h_p),
    .M(h_m), .done(h_done), .busy(h_busy), .err(h_err)
  );

  mont_mul_param #(.WIDTH(8), .START_HOLD(1'b0)) u_b8 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .A(b_a), .B(b_b), .P(b_p),
    .M(b_m), .done(b_done), .busy(b_busy), .err(b_err)
  );

  mont_mul_param #(.WIDTH(256), .START_HOLD(1'b1)) u_w256 (
    .clk(clk), .rst_n(rst_n), .start(w_start), .A(w_a), .B(w_b), .P(w_p),
    .M(w_m), .done(w_done), .busy(w_busy), .err(w_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // A*B*2^-w mod p from modular arithmetic: reduce the product, then
  // multiply by the inverse of 2^w (w successive halvings of 1 mod p).
  function automatic logic [255:0] ref_mont(input logic [255:0] a,
                                            input logic [255:0] b,
                                            input logic [255:0] p,
                                            input int w);
    logic [511:0] prod, rinv, pw;
    pw   = {256'd0, p};
    prod = ({256'd0, a} * {256'd0, b}) % pw;
    rinv = 512'd1;
    for (int i = 0; i < w; i++) begin
      rinv = rinv[0] ? ((rinv + pw) >> 1) : (rinv >> 1);
    end
    prod = (prod * rinv) % pw;
    return prod[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Issue one request on u_h8 and return the edge count from accept to done
  // (-1 if it never came). Called just after a rising edge.
  task automatic h_run(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] p, input bit hold_start,
                       output int lat);
    h_a = a; h_b = b; h_p = p; h_start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) h_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (h_done) begin lat = k; break; end
    end
  endtask

  int lat;
  int pulses;
  logic [255:0] ra, rb, rp;

  initial begin
    rst_n = 1'b0;
    h_start = 1'b0; h_a = '0; h_b = '0; h_p = 8'd101;
    b_start = 1'b0; b_a = '0; b_b = '0; b_p = 8'd101;
    w_start = 1'b0; w_a = '0; w_b = '0; w_p = 256'd3;
    repeat (3) @(posedge clk); #1;
    check_val("rst_m",    256'(h_m),    256'd0);
    check_val("rst_done", 256'(h_done), 256'd0);
    check_val("rst_busy", 256'(h_busy), 256'd0);
    check_val("rst_err",  256'(h_err),  256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3*5, start held high throughout: must not re-accept after done
    h_run(8'd3, 8'd5, 8'd101, 1'b1, lat);
    check_val("t1_lat", 256'(lat),   256'd9);
    check_val("t1_m",   256'(h_m),   256'd62);
    check_val("t1_err", 256'(h_err), 256'd0);
    @(posedge clk); #1;
    check_val("t1_done_one_cycle", 256'(h_done), 256'd0);
    check_val("t1_no_reaccept",    256'(h_busy), 256'd0);
    h_start = 1'b0;
    @(posedge clk); #1;

    // even modulus
    h_run(8'd5, 8'd9, 8'd100, 1'b0, lat);
    check_val("even_lat", 256'(lat),   256'd1);
    check_val("even_err", 256'(h_err), 256'd1);
    check_val("even_m",   256'(h_m),   256'd0);
    @(posedge clk); #1;
    check_val("even_err_held", 256'(h_err), 256'd1);

    // A=0
    h_run(8'd0, 8'd77, 8'd101, 1'b0, lat);
    check_val("zero_lat", 256'(lat),   256'd9);
    check_val("zero_m",   256'(h_m),   256'd0);
    check_val("zero_err", 256'(h_err), 256'd0);
    @(posedge clk); #1;

    // start re-asserted with new operands while busy
    h_a = 8'd20; h_b = 8'd30; h_p = 8'd101; h_start = 1'b1;
    @(posedge clk); #1;
    h_start = 1'b0;
    repeat (3) @(posedge clk); #1;
    h_start = 1'b1; h_a = 8'd99; h_b = 8'd1; h_p = 8'd55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("busy_ignore_busy", 256'(h_busy), 256'd1);
    h_start = 1'b0;
    lat = -1;
    for (int k = 6; k <= 40; k++) begin
      @(posedge clk); #1;
      if (h_done) begin lat = k; break; end
    end
    check_val("busy_ignore_lat", 256'(lat), 256'd9);
    check_val("busy_ignore_m", 256'(h_m),
              ref_mont(256'd20, 256'd30, 256'd101, 8));
    @(posedge clk); #1;

    // reset after four iterations
    h_a = 8'd3; h_b = 8'd5; h_p = 8'd101; h_start = 1'b1;
    @(posedge clk); #1;
    h_start = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 256'(h_busy), 256'd0);
    check_val("midrst_done", 256'(h_done), 256'd0);
    check_val("midrst_m",    256'(h_m),    256'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (h_done) pulses++;
    end
    check_val("midrst_no_done", 256'(pulses), 256'd0);
    h_run(8'd3, 8'd5, 8'd101, 1'b0, lat);
    check_val("after_rst_lat", 256'(lat), 256'd9);
    check_val("after_rst_m",   256'(h_m), 256'd62);

    // back-to-back on the free-running-start instance
    b_a = 8'd7; b_b = 8'd11; b_p = 8'd101; b_start = 1'b1;
    @(posedge clk); #1;
    b_a = 8'd100; b_b = 8'd100;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (b_done) begin lat = k; break; end
    end
    check_val("b2b_first_lat", 256'(lat),   256'd9);
    check_val("b2b_first_m",   256'(b_m),   256'd22);
    check_val("b2b_first_err", 256'(b_err), 256'd0);
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        check_val("b2b_reaccept", 256'(b_busy), 256'd1);
        b_start = 1'b0;
      end
      if (b_done) begin lat = j; break; end
    end
    check_val("b2b_spacing",  256'(lat), 256'd10);
    check_val("b2b_second_m", 256'(b_m), 256'd58);

    // random 256-bit vectors
    for (int v = 0; v < 250; v++) begin
      rp = rand256();
      if (v % 4 == 1) rp = rp >> $urandom_range(250, 0);
      rp[0] = 1'b1;
      if (rp == 256'd1) rp = 256'd3;
      ra = rand256() % rp;
      rb = rand256() % rp;
      if (v == 0) begin ra = rp - 256'd1; rb = rp - 256'd1; end
      w_a = ra; w_b = rb; w_p = rp; w_start = 1'b1;
      @(posedge clk); #1;
      w_start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 400; k++) begin
        @(posedge clk); #1;
        if (w_done) begin lat = k; break; end
      end
      check_val($sformatf("w256_lat_%0d", v), 256'(lat), 256'd257);
      check_val($sformatf("w256_m_%0d", v), w_m, ref_mont(ra, rb, rp, 256));
      check_val($sformatf("w256_err_%0d", v), 256'(w_err), 256'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
